uart_mmio_ctrl: RTL

UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

---
 rtl/uart_mmio_pkg.sv | 49 ++++
 rtl/uart_mmio_ctrl_rx_fifo.sv | 54 +++++
 rtl/uart_mmio_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared constants for the memory-mapped UART block: opcodes, register offsets
// and the offset decoder used by the CPU-side read mux and write strobes.
package uart_mmio_pkg;

    localparam logic [3:0] IO_BASE_NIB_DEFAULT = 4'h8;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [7:0] OFF_RX_CTRL = 8'h00;
    localparam logic [7:0] OFF_RX_DATA = 8'h04;
    localparam logic [7:0] OFF_TX_CTRL = 8'h08;
    localparam logic [7:0] OFF_TX_DATA = 8'h0C;
    localparam logic [7:0] OFF_CYCLES  = 8'h10;

    typedef enum logic [2:0] {
        REG_RX_CTRL,
        REG_RX_DATA,
        REG_TX_CTRL,
        REG_TX_DATA,
        REG_CYCLES,
        REG_NONE
    } regSel_t;

    function automatic logic isLoadOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic isStoreOp(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic regSel_t decodeOffset(input logic [7:0] off);
        regSel_t sel;
        case (off)
            OFF_RX_CTRL: sel = REG_RX_CTRL;
            OFF_RX_DATA: sel = REG_RX_DATA;
            OFF_TX_CTRL: sel = REG_TX_CTRL;
            OFF_TX_DATA: sel = REG_TX_DATA;
            OFF_CYCLES:  sel = REG_CYCLES;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_rx_fifo.sv
// Synchronous receive FIFO; occupancy count is one bit wider than the pointers
// so full and empty are distinguishable without a spare slot.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      count;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller sitting on the execute stage: decodes I/O loads
// and stores, buffers received bytes, holds one transmit byte, counts cycles.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int         RX_DEPTH    = 8,
    parameter logic [3:0] IO_BASE_NIB = IO_BASE_NIB_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [5:0]  opcode_e,
    input  logic [31:0] addr_e,
    input  logic [7:0]  wdata_e,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic        dmem_block,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);

    logic        inIoRegion;
    logic        ioLoad;
    logic        ioStore;
    regSel_t     regSel;
    logic        rxFull;
    logic        rxEmpty;
    logic        rxPush;
    logic        rxPop;
    logic [7:0]  rxHead;
    logic        txFull;
    logic [7:0]  txHold;
    logic [31:0] cycles;
    logic        txAccept;
    logic        txHandshake;
    logic        cyclesClear;
    logic [19:0] unusedAddrBits;

    assign unusedAddrBits = addr_e[27:8];

    assign inIoRegion = (addr_e[31:28] == IO_BASE_NIB);
    assign ioLoad     = isLoadOp(opcode_e) && inIoRegion;
    assign ioStore    = isStoreOp(opcode_e) && inIoRegion;
    assign regSel     = decodeOffset(addr_e[7:0]);

    assign io_sel     = ioLoad;
    assign dmem_block = ioLoad || ioStore;

    assign uart_dout_ready = !rxFull;
    assign rxPush = uart_dout_valid && !rxFull;
    assign rxPop  = ioLoad && (regSel == REG_RX_DATA) && !stall && !rxEmpty;

    // Acceptance uses the pre-edge txFull, so a store racing a handshake is dropped.
    assign txAccept    = ioStore && (regSel == REG_TX_DATA) && !stall && !txFull;
    assign txHandshake = txFull && uart_din_ready;
    assign cyclesClear = ioStore && (regSel == REG_CYCLES) && !stall;

    assign uart_din       = txHold;
    assign uart_din_valid = txFull;

    uart_rx_fifo #(
        .DEPTH(RX_DEPTH),
        .WIDTH(8)
    ) rxFifo (
        .clk  (clk),
        .reset(reset),
        .push (rxPush),
        .pop  (rxPop),
        .din  (uart_dout),
        .head (rxHead),
        .full (rxFull),
        .empty(rxEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            txFull <= 1'b0;
            txHold <= '0;
            cycles <= '0;
        end else begin
            if (txAccept) begin
                txHold <= wdata_e;
                txFull <= 1'b1;
            end else if (txHandshake) begin
                txFull <= 1'b0;
            end
            cycles <= cyclesClear ? 32'd0 : cycles + 32'd1;
        end
    end

    always_comb begin
        io_rdata = '0;
        if (ioLoad) begin
            case (regSel)
                REG_RX_CTRL: io_rdata = {31'b0, !rxEmpty};
                REG_RX_DATA: io_rdata = {24'b0, rxEmpty ? 8'h00 : rxHead};
                REG_TX_CTRL: io_rdata = {31'b0, !txFull};
                REG_CYCLES:  io_rdata = cycles;
                default:     io_rdata = '0;
            endcase
        end
    end

endmodule
